// File: rtl/uart_tx.sv
// Purpose     : UART transmitter. Serializes one word per frame onto TX_OUT:
//               start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Latency     : TX_OUT falls one clock edge after Data_Valid is sampled in IDLE;
//               the frame lasts (2 + DATA_WIDTH + PAR_EN) * Prescale cycles.
// Backpressure: busy is high for the whole frame; Data_Valid while busy is ignored
//               (no queuing). Holding Data_Valid high gives frames with a one-cycle idle gap.
//
// Ports:
//   CLK        - system / oversampling clock, rising edge
//   RST        - asynchronous active-low reset
//   P_DATA     - word to transmit, sampled at accept
//   Data_Valid - request to send P_DATA
//   PAR_EN     - 1 appends a parity bit, sampled at accept
//   PAR_TYP    - 0 even, 1 odd parity, sampled at accept
//   Prescale   - clock cycles per bit (0 means 2**PRESCALE_WIDTH), sampled at accept
//   TX_OUT     - serial line, idle high, registered
//   busy       - frame in progress, registered

module uart_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BIT_CNT_W-1:0]      LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0]      BIT_ONE  = BIT_CNT_W'(1);
  localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE  = PRESCALE_WIDTH'(1);

  logic [2:0]                state_q,    state_d;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [DATA_WIDTH-1:0]     data_q,     data_d;
  logic                      par_en_q,   par_en_d;
  logic                      parity_q,   parity_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      tx_q,       tx_d;
  logic                      busy_q,     busy_d;

  logic [PRESCALE_WIDTH-1:0] prescale_last;
  logic                      bit_end;

  // Last count of a bit period. The subtraction wraps, so Prescale=0 yields
  // an all-ones terminal count, i.e. a full 2**PRESCALE_WIDTH cycle bit.
  assign prescale_last = prescale_q - CNT_ONE;
  assign bit_end       = (edge_cnt_q == prescale_last);

  // TX_OUT and busy are computed for the *next* state and registered, so the
  // line is driven straight from flops and never glitches on state decode.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    parity_d   = parity_q;
    prescale_d = prescale_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        if (Data_Valid) begin
          // Everything the frame depends on is captured here, so later input
          // changes cannot disturb the frame in flight.
          data_d     = P_DATA;
          par_en_d   = PAR_EN;
          parity_d   = (^P_DATA) ^ PAR_TYP;
          prescale_d = Prescale;
          state_d    = START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end

      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
        if (bit_end) begin
          edge_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = DATA;
          tx_d       = data_q[0];
        end else begin
          edge_cnt_d = edge_cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        tx_d   = data_q[bit_cnt_q];
        busy_d = 1'b1;
        if (bit_end) begin
          edge_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
            tx_d      = data_q[bit_cnt_d];
          end
        end else begin
          edge_cnt_d = edge_cnt_q + CNT_ONE;
        end
      end

      PARITY: begin
        tx_d   = parity_q;
        busy_d = 1'b1;
        if (bit_end) begin
          edge_cnt_d = '0;
          state_d    = STOP;
          tx_d       = 1'b1;
        end else begin
          edge_cnt_d = edge_cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        if (bit_end) begin
          // busy drops on the final edge of the stop bit; a new word can be
          // accepted on the following edge, giving one idle-high cycle.
          edge_cnt_d = '0;
          state_d    = IDLE;
          busy_d     = 1'b0;
        end else begin
          edge_cnt_d = edge_cnt_q + CNT_ONE;
        end
      end

      default: begin
        // Unreachable encodings fall back to a quiet idle line.
        state_d    = IDLE;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      parity_q   <= 1'b0;
      prescale_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      parity_q   <= parity_d;
      prescale_q <= prescale_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: table of frames plus hand-written sequences for
// back-to-back, ignored requests and mid-frame reset. Expected frames are queued
// when a request is driven and compared bit by bit as the line produces them.

module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [4:0] Prescale = 5'd0;
  logic       TX_OUT;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    logic [4:0] prescale;
    int         period;      // cycles per bit
    logic       par_bit;     // expected parity bit when par_en
    int         exp_cycles;  // busy-high cycles for the frame
  } vec_t;

  vec_t sb_q[$];
  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Pop one expected frame and compare the line against it, cycle by cycle.
  // Called at a negedge; the start bit must appear within max_wait negedges.
  task automatic check_frame(input int max_wait);
    vec_t e;
    int   nbits;
    int   waited;
    int   busy_cnt;
    logic exp_bit;
    logic act_bit;
    logic [7:0] rx;
    logic rxpar;

    check("sb_nonempty", 32'(sb_q.size() > 0), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();

    waited = 0;
    while (TX_OUT !== 1'b0 && waited < max_wait) begin
      @(negedge CLK);
      waited++;
    end
    if (TX_OUT !== 1'b0) begin
      check("start_timeout", 32'(TX_OUT), 0);
      return;
    end

    nbits    = e.par_en ? 11 : 10;
    busy_cnt = 0;
    rx       = 8'h00;
    rxpar    = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0)                      exp_bit = 1'b0;
      else if (b <= 8)                 exp_bit = e.data[b-1];
      else if (b == 9 && e.par_en)     exp_bit = e.par_bit;
      else                             exp_bit = 1'b1;
      act_bit = exp_bit;
      for (int c = 0; c < e.period; c++) begin
        if (!(b == 0 && c == 0)) @(negedge CLK);
        if (TX_OUT !== exp_bit) act_bit = TX_OUT;
        if (busy === 1'b1) busy_cnt++;
        if (c == e.period / 2) begin
          if (b >= 1 && b <= 8) rx[b-1] = TX_OUT;
          if (b == 9 && e.par_en) rxpar = TX_OUT;
        end
      end
      check($sformatf("data 0x%02h bit %0d", e.data, b), 32'(act_bit), 32'(exp_bit));
    end

    @(negedge CLK);
    for (int i = 0; i < 64 && busy === 1'b1; i++) begin
      busy_cnt++;
      @(negedge CLK);
    end
    check($sformatf("busy_cycles 0x%02h", e.data), 32'(busy_cnt), 32'(e.exp_cycles));
    check("idle_tx_after_frame", 32'(TX_OUT), 1);
    check("busy_low_after_frame", 32'(busy), 0);
    check("loopback_data", 32'(rx), 32'(e.data));
    if (e.par_en) check("loopback_parity_err", 32'(^{rx, rxpar, e.par_typ}), 0);
  endtask

  // Drive one request for a single cycle, then scramble every sampled input.
  task automatic send(input vec_t v, input bit expect_frame);
    P_DATA     = v.data;
    PAR_EN     = v.par_en;
    PAR_TYP    = v.par_typ;
    Prescale   = v.prescale;
    Data_Valid = 1'b1;
    if (expect_frame) sb_q.push_back(v);
    @(negedge CLK);
    Data_Valid = 1'b0;
    P_DATA     = ~v.data;
    PAR_EN     = ~v.par_en;
    PAR_TYP    = ~v.par_typ;
    Prescale   = 5'd5;
  endtask

  // Line must stay idle for n cycles.
  task automatic check_quiet(input string name, input int n);
    logic [1:0] seen;
    seen = 2'b10;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1 || busy !== 1'b0) seen = {TX_OUT, busy};
    end
    check(name, 32'(seen), 32'(2'b10));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         data   pen   ptyp  presc period pbit cycles
    vt[0] = '{8'hA5, 1'b1, 1'b0, 5'd8,  8,  1'b0, 88};
    vt[1] = '{8'h00, 1'b1, 1'b1, 5'd16, 16, 1'b1, 176};
    vt[2] = '{8'hFF, 1'b0, 1'b0, 5'd4,  4,  1'b0, 40};
    vt[3] = '{8'h81, 1'b0, 1'b0, 5'd0,  32, 1'b0, 320};
    vt[4] = '{8'h5A, 1'b1, 1'b1, 5'd8,  8,  1'b1, 88};
    vt[5] = '{8'h01, 1'b1, 1'b0, 5'd4,  4,  1'b1, 44};
    vt[6] = '{8'h07, 1'b1, 1'b1, 5'd16, 16, 1'b0, 176};

    // Reset state
    #12;
    check("reset_tx", 32'(TX_OUT), 1);
    check("reset_busy", 32'(busy), 0);
    @(negedge CLK);
    RST = 1'b1;
    check_quiet("idle_after_reset", 3);

    // Table of frames
    for (int i = 0; i < 7; i++) begin
      send(vt[i], 1'b1);
      check_frame(4);
    end

    // Data_Valid pulsed mid-frame is ignored and not queued
    send(vt[5], 1'b1);
    fork
      check_frame(4);
      begin
        repeat (10) @(negedge CLK);
        P_DATA     = 8'hEE;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
      end
    join
    check_quiet("no_queued_frame", 20);

    // Data_Valid held high, P_DATA changes mid-frame
    P_DATA     = 8'h3C;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 5'd4;
    Data_Valid = 1'b1;
    sb_q.push_back('{8'h3C, 1'b0, 1'b0, 5'd4, 4, 1'b0, 40});
    sb_q.push_back('{8'hC3, 1'b0, 1'b0, 5'd4, 4, 1'b0, 40});
    fork
      begin
        check_frame(2);
        check_frame(1);
      end
      begin
        repeat (20) @(negedge CLK);
        P_DATA = 8'hC3;
        repeat (40) @(negedge CLK);
        Data_Valid = 1'b0;
      end
    join
    check_quiet("no_third_frame", 20);

    // Reset during data bit 3 of 0x96 (bit 3 = 0)
    send('{8'h96, 1'b1, 1'b0, 5'd8, 8, 1'b0, 88}, 1'b0);
    repeat (34) @(negedge CLK);
    check("pre_reset_bit3", 32'(TX_OUT), 0);
    check("pre_reset_busy", 32'(busy), 1);
    #2 RST = 1'b0;
    #1;
    check("async_reset_tx", 32'(TX_OUT), 1);
    check("async_reset_busy", 32'(busy), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    check_quiet("no_resume_after_reset", 12);
    send(vt[0], 1'b1);
    check_frame(4);

    check("scoreboard_drained", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
